id_issue_queue: RTL and testbench

ID_ISSUE_QUEUE -- requirements
Module: id_issue_queue

---
 rtl/id_issue_queue.sv | 156 +++++++++++++++
 tb/tb_id_issue_queue.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/id_issue_queue.sv
// id_issue_queue: circular FIFO between decode and issue.
//
// Buffers up to DEPTH decoded instructions (packed scoreboard entry, original
// 32-bit encoding and a control-flow flag) and presents them to the issue stage
// in arrival order. At most one control-flow instruction may be buffered at a
// time. A flush discards everything buffered and suppresses that cycle's
// handshakes.
//
// Optional feature (macro ID_ISSUE_QUEUE_BYPASS_EN): when the queue is empty
// and not flushing, the decode payload is forwarded combinationally to the
// issue outputs; if issued in the same cycle it is never written.
//
// Parameters:
//   DEPTH   - number of entries (power of two, >= 2)
//   ENTRY_W - width of the packed decoded entry
// Ports:
//   clk_i, rst_ni                         - clock, async active-low reset
//   flush_i                               - drop all unissued entries
//   decoded_instr_i/orig_instr_i/
//   is_ctrl_flow_i/decoded_instr_valid_i  - decode-side payload and valid
//   decoded_instr_ack_o                   - entry accepted from decode
//   issue_instr_o/issue_orig_instr_o/
//   issue_is_ctrl_flow_o                  - head entry payload
//   issue_instr_valid_o                   - head entry valid
//   issue_ack_i                           - issue stage consumed head
//   count_o, full_o                       - occupancy, occupancy == DEPTH
//   ctrl_flow_pending_o                   - a buffered entry is control-flow
module id_issue_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ENTRY_W = 128
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [ENTRY_W-1:0]       decoded_instr_i,
  input  logic [31:0]              orig_instr_i,
  input  logic                     is_ctrl_flow_i,
  input  logic                     decoded_instr_valid_i,
  output logic                     decoded_instr_ack_o,
  output logic [ENTRY_W-1:0]       issue_instr_o,
  output logic [31:0]              issue_orig_instr_o,
  output logic                     issue_is_ctrl_flow_o,
  output logic                     issue_instr_valid_o,
  input  logic                     issue_ack_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     ctrl_flow_pending_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic               ctrl;
    logic [31:0]        orig;
    logic [ENTRY_W-1:0] instr;
  } slot_t;

  slot_t           mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            pending_q, pending_d;

  slot_t in_slot;
  slot_t head;
  logic  empty;
  logic  push;
  logic  pop;
  logic  wr_en;
  logic  rd_en;

  assign in_slot = '{ctrl: is_ctrl_flow_i, orig: orig_instr_i, instr: decoded_instr_i};
  assign empty   = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));

  // Ack looks only at local state and decode inputs, never at issue_ack_i, so a
  // full queue frees a slot one cycle before it can accept again. Gated by
  // rst_ni so no handshake is offered while reset is held.
  assign decoded_instr_ack_o = rst_ni & decoded_instr_valid_i & ~full_o & ~flush_i &
                               ~(is_ctrl_flow_i & pending_q);

`ifdef ID_ISSUE_QUEUE_BYPASS_EN
  logic bypass;

  assign bypass              = empty & ~flush_i;
  assign head                = bypass ? in_slot : mem_q[rd_ptr_q];
  assign issue_instr_valid_o = rst_ni & (bypass ? decoded_instr_valid_i : (~empty & ~flush_i));
  assign push                = decoded_instr_valid_i & decoded_instr_ack_o;
  assign pop                 = issue_instr_valid_o & issue_ack_i;
  // A bypassed entry consumed the same cycle never touches storage.
  assign wr_en               = push & ~(bypass & pop);
  assign rd_en               = pop & ~bypass;
`else
  assign head                = mem_q[rd_ptr_q];
  assign issue_instr_valid_o = rst_ni & ~empty & ~flush_i;
  assign push                = decoded_instr_valid_i & decoded_instr_ack_o;
  assign pop                 = issue_instr_valid_o & issue_ack_i;
  assign wr_en               = push;
  assign rd_en               = pop;
`endif

  assign issue_instr_o        = head.instr;
  assign issue_orig_instr_o   = head.orig;
  assign issue_is_ctrl_flow_o = head.ctrl;

  assign count_o             = count_q;
  assign ctrl_flow_pending_o = pending_q;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    pending_d = pending_q;
    if (flush_i) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      pending_d = 1'b0;
    end else begin
      // Pointer width equals log2(DEPTH), so increment wraps DEPTH-1 -> 0.
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CntW'(wr_en) - CntW'(rd_en);
      // A control-flow push is only accepted while none is pending, and a
      // control-flow pop only happens while one is pending: never both.
      if (wr_en && is_ctrl_flow_i) begin
        pending_d = 1'b1;
      end else if (rd_en && mem_q[rd_ptr_q].ctrl) begin
        pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  // Storage needs no reset: validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= in_slot;
    end
  end

endmodule

// File: tb/tb_id_issue_queue.sv
// Self-checking bench for id_issue_queue: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_id_issue_queue;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned ENTRY_W = 128;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;
`ifdef ID_ISSUE_QUEUE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  typedef struct packed {
    logic               ctrl;
    logic [31:0]        orig;
    logic [ENTRY_W-1:0] instr;
  } ent_t;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               flush_i = 1'b0;
  logic [ENTRY_W-1:0] decoded_instr_i = '0;
  logic [31:0]        orig_instr_i = '0;
  logic               is_ctrl_flow_i = 1'b0;
  logic               decoded_instr_valid_i = 1'b0;
  logic               decoded_instr_ack_o;
  logic [ENTRY_W-1:0] issue_instr_o;
  logic [31:0]        issue_orig_instr_o;
  logic               issue_is_ctrl_flow_o;
  logic               issue_instr_valid_o;
  logic               issue_ack_i = 1'b0;
  logic [CW-1:0]      count_o;
  logic               full_o;
  logic               ctrl_flow_pending_o;

  int n_checks = 0;
  int n_errors = 0;
  ent_t q[$];

  always #5 clk_i = ~clk_i;

  id_issue_queue #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .flush_i               (flush_i),
    .decoded_instr_i       (decoded_instr_i),
    .orig_instr_i          (orig_instr_i),
    .is_ctrl_flow_i        (is_ctrl_flow_i),
    .decoded_instr_valid_i (decoded_instr_valid_i),
    .decoded_instr_ack_o   (decoded_instr_ack_o),
    .issue_instr_o         (issue_instr_o),
    .issue_orig_instr_o    (issue_orig_instr_o),
    .issue_is_ctrl_flow_o  (issue_is_ctrl_flow_o),
    .issue_instr_valid_o   (issue_instr_valid_o),
    .issue_ack_i           (issue_ack_i),
    .count_o               (count_o),
    .full_o                (full_o),
    .ctrl_flow_pending_o   (ctrl_flow_pending_o)
  );

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic cycle(input logic v, input logic cf, input logic ia, input logic fl);
    ent_t in_e;
    logic pend, byp, exp_ack, exp_valid, popped;
    decoded_instr_valid_i = v;
    is_ctrl_flow_i        = cf;
    issue_ack_i           = ia;
    flush_i               = fl;
    decoded_instr_i       = {$urandom, $urandom, $urandom, $urandom};
    orig_instr_i          = $urandom;
    in_e = '{ctrl: cf, orig: orig_instr_i, instr: decoded_instr_i};
    #3;
    pend = 1'b0;
    foreach (q[i]) if (q[i].ctrl) pend = 1'b1;
    byp       = Byp && (q.size() == 0) && !fl;
    exp_ack   = v && (q.size() < DEPTH) && !fl && !(cf && pend);
    exp_valid = byp ? v : ((q.size() != 0) && !fl);
    check("count", count_o, q.size());
    check("full", full_o, q.size() == DEPTH);
    check("pending", ctrl_flow_pending_o, pend);
    check("ack", decoded_instr_ack_o, exp_ack);
    check("valid", issue_instr_valid_o, exp_valid);
    if (exp_valid) begin
      check("head", {issue_is_ctrl_flow_o, issue_orig_instr_o, issue_instr_o},
            byp ? in_e : q[0]);
    end
    @(posedge clk_i);
    if (fl) begin
      q.delete();
    end else begin
      popped = exp_valid && ia;
      if (!(byp && popped)) begin
        if (popped) void'(q.pop_front());
        if (exp_ack) q.push_back(in_e);
      end
    end
    #1;
  endtask

  // Asynchronous assertion mid-cycle with decode still requesting.
  task automatic apply_reset();
    decoded_instr_valid_i = 1'b1;
    issue_ack_i           = 1'b1;
    flush_i               = 1'b0;
    rst_ni                = 1'b0;
    #2;
    check("rst_ack", decoded_instr_ack_o, 1'b0);
    check("rst_valid", issue_instr_valid_o, 1'b0);
    check("rst_count", count_o, 0);
    check("rst_full", full_o, 1'b0);
    check("rst_pending", ctrl_flow_pending_o, 1'b0);
    q.delete();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    apply_reset();
    // Fill A..D, fifth push refused while full.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    // Pop A while full; E accepted next cycle; drain in order.
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    // Steady push/pop at count 2 with pointer wrap.
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    // Second branch waits for the first to pop.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    // Flush at count 3 with decode valid.
    for (int i = 0; i < 3; i++) cycle(1'b1, i == 1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    // Empty queue, decode valid with issue ack.
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    // Reset with entries buffered.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    apply_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        apply_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
      end
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
